// File: rtl/rom_pkg.sv
// Shared definitions for the instruction ROM and its program loader.
// No logic here; types and constants only.
package rom_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_mem.sv
// Instruction storage: DEPTH_WORDS x 32, one synchronous write port, one asynchronous read port.
// Read latency 0; write visible the cycle after the write edge; no backpressure.
module inst_mem #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  // Deliberately unreset: program contents survive core and loader resets.
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch-port instruction ROM with a byte-serial program loader that holds the core in reset while loading.
// Read latency 0 (combinational); loader takes one byte per cycle whenever in LOAD, producer may stall freely.
module inst_rom_loader
  import rom_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_addr_i,
  output logic [31:0]     inst_o,
  input  logic            load_start_i,
  input  logic [ADDR_W:0] load_words_i,
  input  logic            load_valid_i,
  input  logic [7:0]      load_data_i,
  output logic            load_ready_o,
  output logic            core_rst_o,
  output logic            load_done_o
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [1:0]        byte_cnt_q;
  logic [2:0][7:0]   asm_q;
  logic              done_q;

  logic              byte_acc;
  logic              word_wr;
  logic              last_word;
  logic              mem_we;
  logic [ADDR_W:0]   words_clamped;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              out_of_range;
  logic              unused_addr_lsb;

  assign words_clamped = (load_words_i > DEPTH_CNT) ? DEPTH_CNT : load_words_i;
  assign last_word     = (wr_cnt_q + CNT_ONE) == count_q;

  always_comb begin
    state_d      = state_q;
    load_ready_o = 1'b0;
    core_rst_o   = 1'b0;
    byte_acc     = 1'b0;
    word_wr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start_i && (load_words_i != '0)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ready_o = 1'b1;
        core_rst_o   = 1'b1;
        byte_acc     = load_valid_i;
        word_wr      = byte_acc && (byte_cnt_q == 2'd3);
        if (word_wr && last_word) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        core_rst_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      wr_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FLUSH);
      if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
        count_q    <= words_clamped;
        wr_cnt_q   <= '0;
        wr_ptr_q   <= '0;
        byte_cnt_q <= '0;
      end
      if (byte_acc) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    asm_q[0] <= load_data_i;
          2'd1:    asm_q[1] <= load_data_i;
          2'd2:    asm_q[2] <= load_data_i;
          default: ;
        endcase
      end
      if (word_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        wr_cnt_q <= wr_cnt_q + CNT_ONE;
      end
    end
  end

  // The 4th byte bypasses the assembly register straight into the write data.
  assign mem_wdata = {load_data_i, asm_q[2], asm_q[1], asm_q[0]};
  assign mem_we    = word_wr && !rst;

  inst_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_inst_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(mem_wdata),
    .raddr(inst_addr_i[ADDR_W+1:2]),
    .rdata(mem_rdata)
  );

  assign out_of_range    = |inst_addr_i[31:ADDR_W+2];
  assign unused_addr_lsb = ^inst_addr_i[1:0];
  assign inst_o          = ((state_q != ST_IDLE) || out_of_range) ? INST_NOP : mem_rdata;
  assign load_done_o     = done_q;

endmodule
